delay_line_mc: RTL and testbench

Multi-channel, sample-strobed programmable delay line. It succeeds the single-channel fixed shift delay in the DSP datapath. Each of C channels delays a signed N-bit stream by an independently programmed number of valid samples, from 0 to MAX_DELAY. Storage is a circular buffer with an address pointer instead of a shifting register file. Delays can be reprogrammed at run time, and a zero-fill mask hides unwritten history.

---
 rtl/delay_pkg.sv | 38 +++
 rtl/delay_ring_mem.sv | 43 ++++
 rtl/delay_line_mc.sv | 150 +++++++++++++++
 tb/tb_delay_line_mc.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// Shared helpers for the multi-channel programmable delay line: index widths
// and the modulo read-address calculation used by the circular buffer.
package delay_pkg;

  // Reference geometry of the DSP datapath instance.
  localparam int unsigned DELAY_N_DEFAULT         = 16;
  localparam int unsigned DELAY_C_DEFAULT         = 4;
  localparam int unsigned DELAY_MAX_DELAY_DEFAULT = 40;

  // ceil(log2(x)), but never less than 1 so a single-entry index still has a bit.
  function automatic int unsigned clog2_min1(input int unsigned x);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(x)) begin
        r = i + 1;
      end
    end
    return (r == 0) ? 1 : r;
  endfunction

  // Width of a delay field able to hold 0..max_delay inclusive.
  function automatic int unsigned delay_width(input int unsigned max_delay);
    return clog2_min1(max_delay + 1);
  endfunction

  // Delay-field width of the reference instance.
  localparam int unsigned DELAY_DW_DEFAULT = delay_width(DELAY_MAX_DELAY_DEFAULT);

  // Address d entries behind ptr in a ring of 'depth' entries. Depth need not
  // be a power of two, so the wrap is an explicit compare-and-add.
  function automatic int unsigned wrap_sub(input int unsigned ptr,
                                           input int unsigned d,
                                           input int unsigned depth);
    return (ptr >= d) ? (ptr - d) : (ptr + depth - d);
  endfunction

endpackage

// File: rtl/delay_ring_mem.sv
// Circular sample store: DEPTH words of C*N bits, one wide write port and one
// combinational read port per channel, each returning only its own lane.
module delay_ring_mem
  import delay_pkg::*;
#(
  parameter int unsigned N     = 16,
  parameter int unsigned C     = 4,
  parameter int unsigned DEPTH = 40,
  parameter int unsigned AW    = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [C*N-1:0]        wdata,
  input  logic [C-1:0][AW-1:0]  raddr,
  output logic [C-1:0][N-1:0]   rdata
);

  logic [C*N-1:0] mem_q [DEPTH];
  logic [C*N-1:0] mem_d [DEPTH];

  // Next-state of the array: only the addressed word changes on a write.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Storage carries no reset; stale history is masked by the fill counter.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Per-channel read ports see the pre-write contents of the cycle.
  always_comb begin
    rdata = '0;
    for (int unsigned c = 0; c < C; c++) begin
      rdata[c] = mem_q[raddr[c]][c*N +: N];
    end
  end

endmodule

// File: rtl/delay_line_mc.sv
// Multi-channel sample-strobed programmable delay line. Each channel delays its
// signed stream by 0..MAX_DELAY valid samples using a shared circular buffer;
// unwritten history reads back as zero until enough samples have arrived.
module delay_line_mc
  import delay_pkg::*;
#(
  parameter  int unsigned N             = 16,
  parameter  int unsigned C             = 4,
  parameter  int unsigned MAX_DELAY     = 40,
  parameter  int unsigned DEFAULT_DELAY = 0,
  localparam int unsigned DW            = delay_width(MAX_DELAY),
  localparam int unsigned CW            = clog2_min1(C)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [C*N-1:0]  in_data,
  input  logic            flush,
  input  logic            cfg_we,
  input  logic [CW-1:0]   cfg_ch,
  input  logic [DW-1:0]   cfg_delay,
  output logic            cfg_err,
  output logic            out_valid,
  output logic [C*N-1:0]  out_data,
  output logic [DW-1:0]   fill_cnt
);

  localparam int unsigned W = C * N;
  localparam logic [DW-1:0] MAX_Q     = DW'(MAX_DELAY);
  localparam logic [DW-1:0] LAST_PTR  = DW'(MAX_DELAY - 1);
  localparam logic [DW-1:0] DEFAULT_Q =
    DW'((DEFAULT_DELAY > MAX_DELAY) ? MAX_DELAY : DEFAULT_DELAY);

  logic [DW-1:0]        wptr_q, wptr_d;
  logic [DW-1:0]        fill_q, fill_d;
  logic [C-1:0][DW-1:0] delay_q, delay_d;
  logic                 out_valid_q, out_valid_d;
  logic [W-1:0]         out_data_q, out_data_d;
  logic                 cfg_err_q, cfg_err_d;

  logic                 accept;
  logic                 cfg_ch_ok;
  logic                 cfg_clamp;
  logic [DW-1:0]        cfg_delay_sat;
  logic [C-1:0][DW-1:0] rd_addr;
  logic [C-1:0][N-1:0]  rd_data;

  // A flush discards any sample presented in the same cycle.
  assign accept = in_valid & ~flush;

  delay_ring_mem #(
    .N     (N),
    .C     (C),
    .DEPTH (MAX_DELAY),
    .AW    (DW)
  ) u_mem (
    .clk   (clk),
    .we    (accept),
    .waddr (wptr_q),
    .wdata (in_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Read address per channel: d samples behind the write pointer, modulo depth.
  always_comb begin
    rd_addr = '0;
    for (int unsigned c = 0; c < C; c++) begin
      rd_addr[c] = DW'(wrap_sub(32'(wptr_q), 32'(delay_q[c]), MAX_DELAY));
    end
  end

  // Output selection: pass-through, stored history, or zero while priming.
  always_comb begin
    out_valid_d = accept;
    out_data_d  = out_data_q;
    if (accept) begin
      for (int unsigned c = 0; c < C; c++) begin
        if (delay_q[c] == '0) begin
          out_data_d[c*N +: N] = in_data[c*N +: N];
        end else if (fill_q >= delay_q[c]) begin
          out_data_d[c*N +: N] = rd_data[c];
        end else begin
          out_data_d[c*N +: N] = '0;
        end
      end
    end
  end

  // Write pointer wraps at MAX_DELAY-1; fill count saturates at MAX_DELAY.
  always_comb begin
    wptr_d = wptr_q;
    fill_d = fill_q;
    if (flush) begin
      wptr_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + DW'(1);
      fill_d = (fill_q == MAX_Q) ? fill_q : fill_q + DW'(1);
    end
  end

  // Delay programming: clamp oversize values, drop writes to absent channels.
  always_comb begin
    cfg_ch_ok     = 32'(cfg_ch) < C;
    cfg_clamp     = 32'(cfg_delay) > MAX_DELAY;
    cfg_delay_sat = cfg_clamp ? MAX_Q : cfg_delay;
    delay_d       = delay_q;
    cfg_err_d     = 1'b0;
    if (cfg_we) begin
      if (!cfg_ch_ok) begin
        cfg_err_d = 1'b1;
      end else begin
        cfg_err_d = cfg_clamp;
        for (int unsigned c = 0; c < C; c++) begin
          if (32'(cfg_ch) == c) begin
            delay_d[c] = cfg_delay_sat;
          end
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cfg_err_q   <= 1'b0;
      for (int unsigned c = 0; c < C; c++) begin
        delay_q[c] <= DEFAULT_Q;
      end
    end else begin
      wptr_q      <= wptr_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cfg_err_q   <= cfg_err_d;
      delay_q     <= delay_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign cfg_err   = cfg_err_q;
  assign fill_cnt  = fill_q;

endmodule

// File: tb/tb_delay_line_mc.sv
// Self-checking bench for delay_line_mc: constant vector table after reset,
// then scoreboarded directed sequences backed by a sample-history model.
module tb_delay_line_mc;

  // Five channels so the 3-bit channel index can name a channel that does not exist.
  localparam int unsigned N    = 16;
  localparam int unsigned C    = 5;
  localparam int unsigned MAXD = 40;
  localparam int unsigned DEFD = 0;
  localparam int unsigned W    = C * N;
  localparam int unsigned DW   = 6;
  localparam int unsigned CW   = 3;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          flush;
  logic          cfg_we;
  logic [CW-1:0] cfg_ch;
  logic [DW-1:0] cfg_delay;
  logic          cfg_err;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [DW-1:0] fill_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  delay_line_mc #(
    .N             (N),
    .C             (C),
    .MAX_DELAY     (MAXD),
    .DEFAULT_DELAY (DEFD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .flush     (flush),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_delay (cfg_delay),
    .cfg_err   (cfg_err),
    .out_valid (out_valid),
    .out_data  (out_data),
    .fill_cnt  (fill_cnt)
  );

  typedef struct {
    logic          v;
    logic [W-1:0]  data;
    logic          err;
    logic [DW-1:0] fill;
  } exp_t;

  typedef struct {
    logic          v;
    logic [N-1:0]  d0;
    logic [N-1:0]  d1;
    logic          we;
    logic [CW-1:0] ch;
    logic [DW-1:0] dly;
    logic          xv;
    logic [N-1:0]  x0;
    logic [N-1:0]  x1;
    logic          xerr;
    logic [DW-1:0] xfill;
  } vec_t;

  exp_t         sbq[$];
  int unsigned  n_assert;
  int unsigned  n_fail;

  // Model: full history of accepted samples since reset/flush, plus delays.
  int unsigned  m_delay [C];
  logic [W-1:0] m_hist[$];
  logic [W-1:0] m_last;
  int unsigned  m_fill;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] lane(input logic [W-1:0] w, input int unsigned c);
    return w[c*N +: N];
  endfunction

  function automatic logic [W-1:0] mk2(input logic [N-1:0] d0, input logic [N-1:0] d1);
    logic [W-1:0] w;
    w = '0;
    w[0 +: N] = d0;
    w[N +: N] = d1;
    return w;
  endfunction

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] w;
    for (int unsigned c = 0; c < C; c++) begin
      w[c*N +: N] = N'($urandom);
    end
    return w;
  endfunction

  task automatic model_reset();
    for (int unsigned c = 0; c < C; c++) m_delay[c] = DEFD;
    m_hist.delete();
    m_last = '0;
    m_fill = 0;
  endtask

  // Drive one cycle, push the model's expectation, compare after the edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic fl,
                      input logic we, input logic [CW-1:0] ch, input logic [DW-1:0] dly);
    exp_t         e;
    exp_t         g;
    int unsigned  cnt;
    int unsigned  dd;
    logic [W-1:0] old;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    flush     = fl;
    cfg_we    = we;
    cfg_ch    = ch;
    cfg_delay = dly;
    e.v   = v && !fl;
    e.err = we && ((ch >= C) || (dly > MAXD));
    if (v && !fl) begin
      cnt = m_hist.size();
      for (int unsigned c = 0; c < C; c++) begin
        dd = m_delay[c];
        if (dd == 0) begin
          m_last[c*N +: N] = d[c*N +: N];
        end else if (cnt >= dd) begin
          old = m_hist[cnt-dd];
          m_last[c*N +: N] = old[c*N +: N];
        end else begin
          m_last[c*N +: N] = '0;
        end
      end
    end
    e.data = m_last;
    if (fl) begin
      m_hist.delete();
      m_fill = 0;
    end else if (v) begin
      m_hist.push_back(d);
      if (m_fill < MAXD) m_fill++;
    end
    e.fill = DW'(m_fill);
    if (we && (ch < C)) m_delay[ch] = (dly > MAXD) ? MAXD : int'(dly);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    g = sbq.pop_front();
    check("sb out_valid", W'(out_valid), W'(g.v));
    check("sb out_data", out_data, g.data);
    check("sb cfg_err", W'(cfg_err), W'(g.err));
    check("sb fill_cnt", W'(fill_cnt), W'(g.fill));
  endtask

  task automatic samp(input logic [W-1:0] d);
    step(1'b1, d, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic cfg(input logic [CW-1:0] ch, input logic [DW-1:0] dly);
    step(1'b0, '0, 1'b0, 1'b1, ch, dly);
  endtask

  // Called right after a step returns (1 time unit past the edge): reset lands between edges.
  task automatic async_reset();
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    cfg_we   = 1'b0;
    #1;
    check("rst out_valid", W'(out_valid), '0);
    check("rst out_data", out_data, '0);
    check("rst cfg_err", W'(cfg_err), '0);
    check("rst fill_cnt", W'(fill_cnt), '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t         tbl [10];
  logic [W-1:0] w;

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    cfg_we    = 1'b0;
    cfg_ch    = '0;
    cfg_delay = '0;
    model_reset();

    //            v     d0      d1      we    ch    dly    xv    x0      x1      xerr  xfill
    tbl[0] = '{1'b1, 16'd1,  16'd11, 1'b0, 3'd0, 6'd0,  1'b1, 16'd1,  16'd11, 1'b0, 6'd1};
    tbl[1] = '{1'b1, 16'd2,  16'd12, 1'b0, 3'd0, 6'd0,  1'b1, 16'd2,  16'd12, 1'b0, 6'd2};
    tbl[2] = '{1'b0, 16'd99, 16'd99, 1'b0, 3'd0, 6'd0,  1'b0, 16'd2,  16'd12, 1'b0, 6'd2};
    tbl[3] = '{1'b1, 16'd3,  16'd13, 1'b1, 3'd1, 6'd2,  1'b1, 16'd3,  16'd13, 1'b0, 6'd3};
    tbl[4] = '{1'b1, 16'd4,  16'd14, 1'b0, 3'd0, 6'd0,  1'b1, 16'd4,  16'd12, 1'b0, 6'd4};
    tbl[5] = '{1'b1, 16'd5,  16'd15, 1'b0, 3'd0, 6'd0,  1'b1, 16'd5,  16'd13, 1'b0, 6'd5};
    tbl[6] = '{1'b0, 16'd0,  16'd0,  1'b1, 3'd5, 6'd3,  1'b0, 16'd5,  16'd13, 1'b1, 6'd5};
    tbl[7] = '{1'b0, 16'd0,  16'd0,  1'b1, 3'd0, 6'd45, 1'b0, 16'd5,  16'd13, 1'b1, 6'd5};
    tbl[8] = '{1'b1, 16'd6,  16'd16, 1'b0, 3'd0, 6'd0,  1'b1, 16'd0,  16'd14, 1'b0, 6'd6};
    tbl[9] = '{1'b0, 16'd0,  16'd0,  1'b0, 3'd0, 6'd0,  1'b0, 16'd0,  16'd14, 1'b0, 6'd6};

    // Power-on reset with a clean falling edge.
    #1 rst_n = 1'b0;
    #2;
    check("por out_valid", W'(out_valid), '0);
    check("por out_data", out_data, '0);
    check("por cfg_err", W'(cfg_err), '0);
    check("por fill_cnt", W'(fill_cnt), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: defaults, hold on idle, coincident config, clamp, bad channel.
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v, mk2(tbl[i].d0, tbl[i].d1), 1'b0, tbl[i].we, tbl[i].ch, tbl[i].dly);
      check($sformatf("vec%0d out_valid", i), W'(out_valid), W'(tbl[i].xv));
      check($sformatf("vec%0d ch0", i), W'(lane(out_data, 0)), W'(tbl[i].x0));
      check($sformatf("vec%0d ch1", i), W'(lane(out_data, 1)), W'(tbl[i].x1));
      check($sformatf("vec%0d cfg_err", i), W'(cfg_err), W'(tbl[i].xerr));
      check($sformatf("vec%0d fill_cnt", i), W'(fill_cnt), W'(tbl[i].xfill));
    end

    // ch1 delay 5: five zeros then 10,20,...; fill saturates at 40.
    async_reset();
    cfg(3'd1, 6'd5);
    for (int k = 1; k <= 45; k++) begin
      w = rnd_word();
      w[N +: N] = N'(10 * k);
      samp(w);
      check("dly5 ch1", W'(lane(out_data, 1)), W'((k > 5) ? N'(10 * (k - 5)) : N'(0)));
      check("dly5 fill", W'(fill_cnt), W'((k >= 40) ? 40 : k));
    end

    // ch2 at full depth across several pointer wraps.
    async_reset();
    cfg(3'd2, 6'd40);
    for (int k = 1; k <= 100; k++) begin
      w = rnd_word();
      w[2*N +: N] = N'(k);
      samp(w);
      check("dly40 ch2", W'(lane(out_data, 2)), W'((k > 40) ? N'(k - 40) : N'(0)));
    end

    // ch3: run at 3, reprogram to 7 coincident with a sample, then clamp and bad channel.
    cfg(3'd3, 6'd3);
    for (int k = 1; k <= 50; k++) begin
      w = rnd_word();
      w[3*N +: N] = N'(1000 + k);
      samp(w);
      if (k > 3) check("dly3 ch3", W'(lane(out_data, 3)), W'(N'(1000 + k - 3)));
    end
    w = rnd_word();
    w[3*N +: N] = N'(1051);
    step(1'b1, w, 1'b0, 1'b1, 3'd3, 6'd7);
    check("cfg same-cycle old delay", W'(lane(out_data, 3)), W'(N'(1048)));
    w = rnd_word();
    w[3*N +: N] = N'(1052);
    samp(w);
    check("cfg new delay 7", W'(lane(out_data, 3)), W'(N'(1045)));
    cfg(3'd3, 6'd45);
    check("clamp cfg_err pulse", W'(cfg_err), W'(1'b1));
    step(1'b0, '0, 1'b0, 1'b0, '0, '0);
    check("clamp cfg_err one cycle", W'(cfg_err), W'(1'b0));
    cfg(3'd5, 6'd2);
    check("bad ch cfg_err", W'(cfg_err), W'(1'b1));
    w = rnd_word();
    w[3*N +: N] = N'(1053);
    samp(w);
    check("clamped delay 40", W'(lane(out_data, 3)), W'(N'(1013)));

    // Flush with a coincident sample at ch0 delay 4; coincident config on ch4.
    cfg(3'd0, 6'd4);
    for (int k = 1; k <= 10; k++) begin
      w = rnd_word();
      w[0 +: N] = N'(500 + k);
      samp(w);
    end
    w = rnd_word();
    w[0 +: N] = N'(777);
    step(1'b1, w, 1'b1, 1'b1, 3'd4, 6'd1);
    check("flush out_valid", W'(out_valid), W'(1'b0));
    check("flush fill_cnt", W'(fill_cnt), W'(6'd0));
    for (int j = 1; j <= 8; j++) begin
      w = rnd_word();
      w[0 +: N] = N'(600 + j);
      samp(w);
      check("post-flush ch0", W'(lane(out_data, 0)), W'((j > 4) ? N'(600 + j - 4) : N'(0)));
    end

    // Asynchronous reset mid-stream, then defaults and zero-fill restart.
    for (int k = 1; k <= 5; k++) samp(rnd_word() | W'(1));
    async_reset();
    w = rnd_word();
    samp(w);
    check("post-rst pass ch3", W'(lane(out_data, 3)), W'(lane(w, 3)));
    cfg(3'd1, 6'd2);
    for (int k = 1; k <= 4; k++) samp(rnd_word());

    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
